// File: rtl/pin_lock_if.sv
// pin_lock_if: digit entry strobes, control requests and status outputs of
// the PIN-entry lock. The master side drives digits and requests, the slave
// side (the lock itself) drives the status outputs.
interface pin_lock_if #(
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 3
);
    localparam int AW = $clog2(MAX_TRIES + 1);

    logic [DIGIT_W-1:0] din;
    logic               din_valid;
    logic               relock;
    logic               prog_en;
    logic               unlocked;
    logic               locked_out;
    logic [AW-1:0]      attempts_left;
    logic               bad_attempt;

    modport master (
        output din, din_valid, relock, prog_en,
        input  unlocked, locked_out, attempts_left, bad_attempt
    );

    modport slave (
        input  din, din_valid, relock, prog_en,
        output unlocked, locked_out, attempts_left, bad_attempt
    );
endinterface

// File: rtl/pin_lock.sv
// pin_lock: generic PIN-entry lock with retry budget, timed lockout,
// inter-digit entry timeout, explicit relock and a per-attempt failure pulse.
// Optional PIN programming while unlocked is built when PIN_PROG_EN is
// defined; otherwise the PIN is the constant DEFAULT_PIN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ENTRY    | collecting digits into the entry shift register
// CHECK    | one-cycle compare of the full entry against the PIN
// UNLOCKED | open; waits for relock (or PIN programming when built)
// LOCKOUT  | retry budget exhausted; all input ignored until the timer ends
module pin_lock #(
    parameter int                         DIGIT_W        = 4,
    parameter int                         PIN_LEN        = 4,
    parameter logic [DIGIT_W*PIN_LEN-1:0] DEFAULT_PIN    = 16'hC0DE,
    parameter int                         MAX_TRIES      = 3,
    parameter int                         LOCKOUT_CYCLES = 64,
    parameter int                         ENTRY_TIMEOUT  = 16
) (
    input logic       clk,
    input logic       reset,
    pin_lock_if.slave bus
);
    localparam int PW = DIGIT_W * PIN_LEN;
    localparam int CW = $clog2(PIN_LEN + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int IW = (ENTRY_TIMEOUT > 0) ? $clog2(ENTRY_TIMEOUT + 1) : 1;

    localparam bit            TIMEOUT_ON = (ENTRY_TIMEOUT > 0);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(PIN_LEN - 1);
    localparam logic [FW-1:0] TRIES      = FW'(MAX_TRIES);
    localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'((ENTRY_TIMEOUT > 0) ? ENTRY_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ENTRY    = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] entry_sr;
    logic [CW-1:0] digit_cnt;
    logic [FW-1:0] fail_cnt;
    logic [LW-1:0] lock_cnt;
    logic [IW-1:0] idle_cnt;

    logic          unlocked_q;
    logic          locked_out_q;
    logic          bad_attempt_q;
    logic [FW-1:0] attempts_left_q;

    logic [PW-1:0] pin_val;
    logic [FW-1:0] fail_inc;

    // New digits enter at the LS end, so the first digit typed ends up MS.
    function automatic logic [PW-1:0] shift_in(input logic [PW-1:0]      sr,
                                               input logic [DIGIT_W-1:0] d);
        return (sr << DIGIT_W) | PW'(d);
    endfunction

    // fail_cnt never sits at MAX_TRIES while in CHECK, so this cannot wrap.
    assign fail_inc = fail_cnt + 1'b1;

`ifdef PIN_PROG_EN
    logic [PW-1:0] pin_reg;
    logic [PW-1:0] stage_sr;
    logic [CW-1:0] prog_cnt;

    assign pin_val = pin_reg;
`else
    logic unused_prog_en;

    assign pin_val        = DEFAULT_PIN;
    assign unused_prog_en = bus.prog_en;
`endif

    // Lock sequencer: state, counters, shift registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ENTRY;
            entry_sr        <= '0;
            digit_cnt       <= '0;
            fail_cnt        <= '0;
            lock_cnt        <= '0;
            idle_cnt        <= '0;
            unlocked_q      <= 1'b0;
            locked_out_q    <= 1'b0;
            bad_attempt_q   <= 1'b0;
            attempts_left_q <= TRIES;
`ifdef PIN_PROG_EN
            pin_reg         <= DEFAULT_PIN;
            stage_sr        <= '0;
            prog_cnt        <= '0;
`endif
        end else begin
            bad_attempt_q <= 1'b0;
            // Status levels are registered views of the current state, which
            // puts the unlocked rise two edges after the final digit.
            unlocked_q    <= (state == UNLOCKED);
            locked_out_q  <= (state == LOCKOUT);

            case (state)
                ENTRY: begin
                    if (bus.din_valid) begin
                        entry_sr <= shift_in(entry_sr, bus.din);
                        idle_cnt <= '0;
                        if (digit_cnt == LAST_DIGIT) begin
                            digit_cnt <= '0;
                            state     <= CHECK;
                        end else begin
                            digit_cnt <= digit_cnt + 1'b1;
                        end
                    end else if (TIMEOUT_ON && (digit_cnt != '0)) begin
                        // A stale partial entry is dropped silently; it does
                        // not count against the retry budget.
                        if (idle_cnt == IDLE_LAST) begin
                            digit_cnt <= '0;
                            idle_cnt  <= '0;
                            entry_sr  <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end

                CHECK: begin
                    // Exact full-width compare; this is the only way into UNLOCKED.
                    if (entry_sr == pin_val) begin
                        state           <= UNLOCKED;
                        fail_cnt        <= '0;
                        attempts_left_q <= TRIES;
                    end else begin
                        bad_attempt_q   <= 1'b1;
                        fail_cnt        <= fail_inc;
                        attempts_left_q <= TRIES - fail_inc;
                        if (fail_inc == TRIES) begin
                            state    <= LOCKOUT;
                            lock_cnt <= LOCK_LOAD;
                        end else begin
                            state <= ENTRY;
                        end
                    end
                end

                UNLOCKED: begin
                    if (bus.relock) begin
                        state    <= ENTRY;
                        entry_sr <= '0;
`ifdef PIN_PROG_EN
                        stage_sr <= '0;
                        prog_cnt <= '0;
`endif
                    end
`ifdef PIN_PROG_EN
                    else if (bus.prog_en) begin
                        if (bus.din_valid) begin
                            if (prog_cnt == LAST_DIGIT) begin
                                // Commit the new PIN and relock automatically.
                                pin_reg  <= shift_in(stage_sr, bus.din);
                                stage_sr <= '0;
                                prog_cnt <= '0;
                                entry_sr <= '0;
                                state    <= ENTRY;
                            end else begin
                                stage_sr <= shift_in(stage_sr, bus.din);
                                prog_cnt <= prog_cnt + 1'b1;
                            end
                        end
                    end else begin
                        // Dropping prog_en mid-sequence abandons the staged PIN.
                        stage_sr <= '0;
                        prog_cnt <= '0;
                    end
`endif
                end

                LOCKOUT: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state           <= ENTRY;
                        lock_cnt        <= '0;
                        fail_cnt        <= '0;
                        attempts_left_q <= TRIES;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end

                default: state <= ENTRY;
            endcase
        end
    end

    assign bus.unlocked      = unlocked_q;
    assign bus.locked_out    = locked_out_q;
    assign bus.bad_attempt   = bad_attempt_q;
    assign bus.attempts_left = attempts_left_q;

endmodule

// File: tb/tb_pin_lock.sv
// tb_pin_lock: scoreboard bench for pin_lock. The driver feeds one cycle of
// inputs at a time into a transaction-level model that predicts output events
// (bad pulse, unlocked rise/fall, locked_out rise/fall) with their edge
// numbers; a monitor pops and compares them as the DUT produces them.
module tb_pin_lock;
    localparam int DIGIT_W        = 4;
    localparam int PIN_LEN        = 4;
    localparam int MAX_TRIES      = 3;
    localparam int LOCKOUT_CYCLES = 64;
    localparam int ENTRY_TIMEOUT  = 16;
    localparam int DEFAULT_PIN    = 'hC0DE;

    localparam int EV_BAD       = 0;
    localparam int EV_UNL_RISE  = 1;
    localparam int EV_UNL_FALL  = 2;
    localparam int EV_LOCK_RISE = 3;
    localparam int EV_LOCK_FALL = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    pin_lock_if #(.DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES)) bus ();

    pin_lock #(
        .DIGIT_W       (DIGIT_W),
        .PIN_LEN       (PIN_LEN),
        .DEFAULT_PIN   (16'hC0DE),
        .MAX_TRIES     (MAX_TRIES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .ENTRY_TIMEOUT (ENTRY_TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int kind;
        int at;
        int left;
    } ev_t;

    ev_t  exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    logic p_unl  = 1'b0;
    logic p_lock = 1'b0;

    // Reference model state, in terms of the lock's rules.
    int m_pin;
    int m_fails;
    int m_last;
    int m_busy_until;
    bit m_unl;
    int m_buf[$];
    int m_stage[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int digits_value(input int q[$]);
        int v = 0;
        foreach (q[i]) v = (v << DIGIT_W) | q[i];
        return v;
    endfunction

    function automatic void expect_ev(input int kind, input int at, input int left);
        exp_q.push_back('{kind: kind, at: at, left: left});
    endfunction

    task automatic model_reset();
        m_pin        = DEFAULT_PIN;
        m_fails      = 0;
        m_last       = -1000;
        m_busy_until = -1000;
        m_unl        = 1'b0;
        m_buf.delete();
        m_stage.delete();
    endtask

    // Apply the inputs sampled at edge n to the model.
    task automatic model_edge(input int n, input bit dv, input int d, input bit rl, input bit pe);
        int value;
        if (n <= m_busy_until) return;
        if (m_unl) begin
            if (rl) begin
                m_unl = 1'b0;
                m_stage.delete();
                m_buf.delete();
                expect_ev(EV_UNL_FALL, n + 1, MAX_TRIES - m_fails);
            end
`ifdef PIN_PROG_EN
            else if (pe) begin
                if (dv) begin
                    m_stage.push_back(d);
                    if (m_stage.size() == PIN_LEN) begin
                        m_pin = digits_value(m_stage);
                        m_stage.delete();
                        m_unl = 1'b0;
                        expect_ev(EV_UNL_FALL, n + 1, MAX_TRIES - m_fails);
                    end
                end
            end else begin
                m_stage.delete();
            end
`else
            begin
                bit pe_unused;
                pe_unused = pe;
            end
`endif
            return;
        end
        if (!dv) return;
        if (ENTRY_TIMEOUT > 0 && m_buf.size() > 0 && (n - m_last - 1) >= ENTRY_TIMEOUT)
            m_buf.delete();
        m_buf.push_back(d);
        m_last = n;
        if (m_buf.size() < PIN_LEN) return;
        value = digits_value(m_buf);
        m_buf.delete();
        m_busy_until = n + 1;
        if (value == m_pin) begin
            m_fails = 0;
            m_unl   = 1'b1;
            expect_ev(EV_UNL_RISE, n + 2, MAX_TRIES);
        end else begin
            m_fails++;
            expect_ev(EV_BAD, n + 1, MAX_TRIES - m_fails);
            if (m_fails == MAX_TRIES) begin
                expect_ev(EV_LOCK_RISE, n + 2, 0);
                expect_ev(EV_LOCK_FALL, n + 2 + LOCKOUT_CYCLES, MAX_TRIES);
                m_busy_until = n + 1 + LOCKOUT_CYCLES;
                m_fails      = 0;
            end
        end
    endtask

    task automatic observe(input int kind, input int now, input int left);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: kind %0d at edge %0d, nothing expected", kind, now);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_edge", now, e.at);
            check("event_attempts_left", left, e.left);
        end
    endtask

    // Monitor: turn output transitions into events and match them in order.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_event: kind %0d due at edge %0d, not seen by edge %0d",
                         exp_q[0].kind, exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
            if (bus.bad_attempt)            observe(EV_BAD,       cyc, int'(bus.attempts_left));
            if (bus.unlocked && !p_unl)     observe(EV_UNL_RISE,  cyc, int'(bus.attempts_left));
            if (!bus.unlocked && p_unl)     observe(EV_UNL_FALL,  cyc, int'(bus.attempts_left));
            if (bus.locked_out && !p_lock)  observe(EV_LOCK_RISE, cyc, int'(bus.attempts_left));
            if (!bus.locked_out && p_lock)  observe(EV_LOCK_FALL, cyc, int'(bus.attempts_left));
        end
        p_unl  = bus.unlocked;
        p_lock = bus.locked_out;
    end

    task automatic step(input bit dv, input int d, input bit rl, input bit pe);
        @(negedge clk);
        bus.din       = d[DIGIT_W-1:0];
        bus.din_valid = dv;
        bus.relock    = rl;
        bus.prog_en   = pe;
        @(posedge clk);
        #1;
        model_edge(cyc, dv, d, rl, pe);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input int code);
        for (int i = PIN_LEN - 1; i >= 0; i--) step(1'b1, (code >> (DIGIT_W * i)) & 15, 1'b0, 1'b0);
    endtask

    task automatic do_relock();
        step(1'b0, 0, 1'b1, 1'b0);
        idle(2);
    endtask

    // Asynchronous reset a few ns after an edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        mon_en = 1'b0;
        @(negedge clk);
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.relock    = 1'b0;
        bus.prog_en   = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check({tag, "_unlocked"},      int'(bus.unlocked),      0);
        check({tag, "_locked_out"},    int'(bus.locked_out),    0);
        check({tag, "_bad_attempt"},   int'(bus.bad_attempt),   0);
        check({tag, "_attempts_left"}, int'(bus.attempts_left), MAX_TRIES);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.relock    = 1'b0;
        bus.prog_en   = 1'b0;
        model_reset();
        do_reset("reset");

        // Correct PIN, then relock.
        enter_code('hC0DE);
        idle(3);
        do_relock();

        // One bad attempt, then correct PIN restores the budget.
        enter_code('h1234);
        idle(2);
        enter_code('hC0DE);
        idle(3);
        do_relock();

        // Exhaust the budget; digits during lockout are ignored.
        enter_code('h1234);
        idle(2);
        enter_code('h1234);
        idle(2);
        enter_code('hF00F);
        idle(5);
        enter_code('hC0DE);
        idle(70);
        enter_code('hC0DE);
        idle(3);
        do_relock();

        // Entry timeout: 16 idle cycles discard, 15 do not.
        step(1'b1, 'hC, 1'b0, 1'b0);
        step(1'b1, 'h0, 1'b0, 1'b0);
        idle(16);
        enter_code('hC0DE);
        idle(3);
        do_relock();
        step(1'b1, 'hC, 1'b0, 1'b0);
        step(1'b1, 'h0, 1'b0, 1'b0);
        idle(15);
        step(1'b1, 'hD, 1'b0, 1'b0);
        step(1'b1, 'hE, 1'b0, 1'b0);
        idle(3);
        do_relock();

        // Randomized attempts with gaps, stray relocks and stray digits.
        for (int a = 0; a < 40; a++) begin
            int code;
            int sel;
            int k;
            sel  = $urandom_range(0, 3);
            code = (sel <= 1) ? m_pin : ((sel == 2) ? 'hF00F : int'($urandom_range(0, 65535)));
            for (int i = PIN_LEN - 1; i >= 0; i--) begin
                int gap;
                gap = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 1);
                for (int g = 0; g < gap; g++)
                    step(1'b0, $urandom_range(0, 15), ($urandom_range(0, 9) == 0),
                         ($urandom_range(0, 5) == 0));
                step(1'b1, (code >> (DIGIT_W * i)) & 15, 1'b0, 1'b0);
            end
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++)
                step(($urandom_range(0, 3) == 0), $urandom_range(0, 15),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
        end
        idle(80);
        do_relock();

        // Reset in the middle of a lockout and in the middle of an entry.
        do_reset("pre_lock");
        for (int t = 0; t < MAX_TRIES; t++) begin
            enter_code('h1111 * (t + 1));
            idle(2);
        end
        idle(10);
        check("pre_reset_locked_out", int'(bus.locked_out), 1);
        do_reset("mid_lock");
        step(1'b1, 'hC, 1'b0, 1'b0);
        step(1'b1, 'h0, 1'b0, 1'b0);
        do_reset("mid_entry");
        enter_code('hF00F);
        idle(2);
        enter_code('hC0DE);
        idle(3);
        do_relock();

`ifdef PIN_PROG_EN
        // Program 1357, check old and new PIN, abort paths, then reset.
        enter_code('hC0DE);
        idle(3);
        step(1'b1, 1, 1'b0, 1'b1);
        step(1'b1, 3, 1'b0, 1'b1);
        step(1'b1, 5, 1'b0, 1'b1);
        step(1'b1, 7, 1'b0, 1'b1);
        idle(3);
        enter_code('hC0DE);
        idle(2);
        enter_code('h1357);
        idle(3);
        step(1'b1, 2, 1'b0, 1'b1);
        step(1'b1, 4, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 6, 1'b0, 1'b1);
        step(1'b1, 8, 1'b1, 1'b1);
        idle(2);
        enter_code('h1357);
        idle(3);
        do_relock();
        do_reset("prog");
        enter_code('hC0DE);
        idle(3);
        do_relock();
`endif

        idle(80);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pin_lock.md
Name: pin_lock

Overview:
- Parametrised successor to the 4-digit safe FSM: a generic PIN-entry lock with configurable digit width and PIN length.
- Adds a retry budget with timed lockout, an inter-digit entry timeout, explicit relock, and a per-attempt failure pulse.
- Used as a regression target for assertion checking in the gate-level simulation flow: a single-clock FSM plus counters and a shift register, with no hidden unlock paths.

Parameters:
- DIGIT_W, 4: bits per digit.
- PIN_LEN, 4: digits per PIN, minimum 1.
- DEFAULT_PIN, 16'hC0DE: reset PIN, width DIGIT_W*PIN_LEN; first digit entered is the MS digit.
- MAX_TRIES, 3: consecutive failed attempts allowed before lockout, minimum 1.
- LOCKOUT_CYCLES, 64: lockout duration in clk cycles, minimum 1.
- ENTRY_TIMEOUT, 16: idle cycles after which a partial entry is discarded; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- din  in  DIGIT_W  digit value.
- din_valid  in  1  digit strobe; one digit accepted per cycle while high.
- relock  in  1  returns the block from UNLOCKED to ENTRY.
- prog_en  in  1  PIN programming request (see Optional Feature).
- unlocked  out  1  high while in UNLOCKED.
- locked_out  out  1  high while in LOCKOUT.
- attempts_left  out  $clog2(MAX_TRIES+1)  MAX_TRIES minus the current fail count.
- bad_attempt  out  1  one-cycle pulse on each rejected PIN.

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values:
  - state = ENTRY; digit count = 0; entry shift register = 0; fail count = 0; lockout and idle counters = 0.
  - PIN register = DEFAULT_PIN.
  - Outputs: unlocked = 0, locked_out = 0, bad_attempt = 0, attempts_left = MAX_TRIES.
- States: ENTRY, CHECK, UNLOCKED, LOCKOUT. All outputs are registered.
- ENTRY:
  - On each edge with din_valid = 1, shift din into the LS end of the entry register, increment the digit count and clear the idle counter.
  - On the edge accepting digit PIN_LEN, go to CHECK and clear the digit count.
- CHECK: lasts exactly one cycle, and din is ignored during it. At the next edge:
  - Entry == PIN: go to UNLOCKED and clear the fail count.
  - Otherwise: pulse bad_attempt for one cycle and increment the fail count.
    - If the fail count reaches MAX_TRIES, go to LOCKOUT and load the lockout counter with LOCKOUT_CYCLES.
    - Else return to ENTRY.
- Latency: unlocked rises 2 edges after the edge that accepts the last digit.
- UNLOCKED: din is ignored unless programming is active. relock = 1 goes to ENTRY and clears the entry register. relock takes priority over din_valid in the same cycle.
- LOCKOUT:
  - The counter decrements every cycle; din_valid and relock are ignored.
  - When the counter reaches 1, the next edge goes to ENTRY with fail count = 0.
  - locked_out is high for exactly LOCKOUT_CYCLES cycles.
- Entry timeout (ENTRY_TIMEOUT > 0): in ENTRY with digit count > 0, the idle counter increments on each cycle with din_valid = 0. On reaching ENTRY_TIMEOUT, discard the partial entry (digit count = 0). The fail count does not change and bad_attempt is not pulsed.
- Unlock path: the only route to UNLOCKED is CHECK with an exact full-width compare. No other path into UNLOCKED exists.
- Reset mid-operation: any state returns to the reset values immediately, including a programmed PIN reverting to DEFAULT_PIN.
- Counter widths: each counter is sized by $clog2 of its bound; no wrap-around is permitted.

Optional Feature:
- Macro: PIN_PROG_EN.
- Defined:
  - While UNLOCKED with prog_en = 1, accepted digits shift into a staging register.
  - After PIN_LEN digits, the staging register is copied to the PIN register and the state goes to ENTRY (auto-relock).
  - Deasserting prog_en before PIN_LEN digits discards the staging register and leaves the PIN unchanged.
  - relock during programming aborts it, leaves the PIN unchanged, and goes to ENTRY.
- Not defined: the PIN register is the constant DEFAULT_PIN, prog_en is ignored, and no staging logic is built.

Test Plan:
1. Reset, then enter C,0,D,E on consecutive cycles -> unlocked = 1 two edges after digit E; attempts_left = 3; relock -> unlocked = 0.
2. Enter 1,2,3,4 -> one bad_attempt pulse, attempts_left = 2, unlocked stays 0. Then enter C,0,D,E -> unlocked = 1, attempts_left = 3.
3. Enter 1234, 1234, F00F -> after the third attempt, locked_out = 1 for 64 cycles. Enter C0DE during lockout -> ignored, unlocked = 0. After lockout, enter C0DE -> unlocked = 1.
4. Enter C,0, wait 16 idle cycles, then enter C,0,D,E -> unlocked = 1, no bad_attempt pulse. Repeat with a 15-cycle wait and digits D,E only -> unlocked = 1.
5. Assert reset asynchronously mid-lockout and mid-entry -> all outputs return to their reset values immediately. Backdoor F00F never asserts unlocked in any sequence.
6. With PIN_PROG_EN: unlock, prog_en = 1, enter 1,3,5,7 -> returns to ENTRY. C0DE now fails; 1357 unlocks. After reset, C0DE unlocks again.
